// File: rtl/fc_layer_engine.sv
// Multi-neuron fully connected output stage: LANES MACs per neuron per cycle,
// bias preloaded once, then shift / optional ReLU / saturate and argmax.
module fc_layer_engine #(
  parameter int FLATTENED_LENGTH = 432,
  parameter int DATA_WIDTH       = 8,
  parameter int ACC_WIDTH        = 32,
  parameter int NUM_OUTPUTS      = 4,
  parameter int LANES            = 4,
  parameter int OUT_SHIFT        = 0,
  parameter int RELU_EN          = 1
) (
  input  logic                                                        clk,
  input  logic                                                        reset,
  input  logic                                                        start,
  input  logic [FLATTENED_LENGTH-1:0][DATA_WIDTH-1:0]                 flattened_outfmap,
  input  logic [NUM_OUTPUTS-1:0][FLATTENED_LENGTH-1:0][DATA_WIDTH-1:0] fullyconnected_weights,
  input  logic [NUM_OUTPUTS-1:0][DATA_WIDTH-1:0]                      bias,
  output logic                                                        busy,
  output logic                                                        done,
  output logic [NUM_OUTPUTS-1:0][DATA_WIDTH-1:0]                      fullyconnected_output,
  output logic [$clog2(NUM_OUTPUTS)-1:0]                              class_index
);

  localparam int K      = FLATTENED_LENGTH / LANES;
  localparam int CNT_W  = (K > 1) ? $clog2(K) : 1;
  localparam int BASE_W = (FLATTENED_LENGTH > 1) ? $clog2(FLATTENED_LENGTH) : 1;
  localparam int IDX_W  = $clog2(NUM_OUTPUTS);
  localparam int PW     = 2 * DATA_WIDTH + 1;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, ACCUM, FINALIZE} state_t;

  state_t                        state_q;
  logic [CNT_W-1:0]              beat_q;
  logic signed [ACC_WIDTH-1:0]   acc_q [NUM_OUTPUTS];
  logic signed [ACC_WIDTH-1:0]   acc_d [NUM_OUTPUTS];
  logic signed [DATA_WIDTH-1:0]  sat_val [NUM_OUTPUTS];
  logic [BASE_W-1:0]             base_idx;
  logic [IDX_W-1:0]              best_idx;
  logic signed [DATA_WIDTH-1:0]  best_val;

  assign base_idx = BASE_W'(beat_q) * BASE_W'(LANES);

  for (genvar gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_neuron
    logic [LANES-1:0][DATA_WIDTH-1:0] x_slice;
    logic [LANES-1:0][DATA_WIDTH-1:0] w_slice;
    logic signed [PW-1:0]             prod [LANES];
    logic signed [ACC_WIDTH-1:0]      lane_sum;
    logic signed [ACC_WIDTH-1:0]      shifted;
    logic signed [DATA_WIDTH-1:0]     sat;

    assign x_slice = flattened_outfmap[base_idx +: LANES];
    assign w_slice = fullyconnected_weights[gi][base_idx +: LANES];

    // Activations are unsigned, so zero-extend them before the signed multiply.
    for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
      assign prod[gl] = $signed({{DATA_WIDTH{1'b0}}, x_slice[gl]})
                      * $signed({{(DATA_WIDTH + 1){w_slice[gl][DATA_WIDTH-1]}}, w_slice[gl]});
    end

    always_comb begin
      lane_sum = '0;
      for (int l = 0; l < LANES; l++) begin
        lane_sum = lane_sum + {{(ACC_WIDTH - PW){prod[l][PW-1]}}, prod[l]};
      end
    end

    assign acc_d[gi]  = acc_q[gi] + lane_sum;
    assign shifted    = acc_q[gi] >>> OUT_SHIFT;

    always_comb begin
      if (RELU_EN != 0 && shifted[ACC_WIDTH-1]) begin
        sat = '0;
      end else if (shifted > SAT_MAX) begin
        sat = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
      end else if (shifted < SAT_MIN) begin
        sat = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
      end else begin
        sat = shifted[DATA_WIDTH-1:0];
      end
    end

    assign sat_val[gi] = sat;
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_idx = '0;
    best_val = sat_val[0];
    for (int m = 1; m < NUM_OUTPUTS; m++) begin
      if (sat_val[m] > best_val) begin
        best_val = sat_val[m];
        best_idx = IDX_W'(m);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q               <= IDLE;
      beat_q                <= '0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      fullyconnected_output <= '0;
      class_index           <= '0;
      for (int m = 0; m < NUM_OUTPUTS; m++) acc_q[m] <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            for (int m = 0; m < NUM_OUTPUTS; m++) begin
              acc_q[m] <= {{(ACC_WIDTH - DATA_WIDTH){bias[m][DATA_WIDTH-1]}}, bias[m]};
            end
            beat_q  <= '0;
            busy    <= 1'b1;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          for (int m = 0; m < NUM_OUTPUTS; m++) acc_q[m] <= acc_d[m];
          if (beat_q == CNT_W'(K - 1)) begin
            beat_q  <= '0;
            state_q <= FINALIZE;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        FINALIZE: begin
          for (int m = 0; m < NUM_OUTPUTS; m++) fullyconnected_output[m] <= sat_val[m];
          class_index <= best_idx;
          done        <= 1'b1;
          busy        <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_engine.sv
// Scoreboard bench: three engines (ReLU/shift0, no-ReLU/shift0, no-ReLU/shift4)
// share stimulus; expected results are queued at start and checked on done.
module tb_fc_layer_engine;
  localparam int N  = 8;
  localparam int L  = 2;
  localparam int M  = 3;
  localparam int DW = 8;

  typedef struct packed {
    logic [M-1:0][DW-1:0] o;
    logic [1:0]           idx;
  } res_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [N-1:0][DW-1:0]        x_v;
  logic [M-1:0][N-1:0][DW-1:0] w_v;
  logic [M-1:0][DW-1:0]        b_v;

  logic                 busy_a, done_a, busy_b, done_b, busy_c, done_c;
  logic [M-1:0][DW-1:0] out_a, out_b, out_c;
  logic [1:0]           idx_a, idx_b, idx_c;

  res_t q [3][$];
  res_t exp_tab [3][8];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fc_layer_engine #(.FLATTENED_LENGTH(N), .DATA_WIDTH(DW), .ACC_WIDTH(32), .NUM_OUTPUTS(M),
                    .LANES(L), .OUT_SHIFT(0), .RELU_EN(1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .flattened_outfmap(x_v),
    .fullyconnected_weights(w_v), .bias(b_v), .busy(busy_a), .done(done_a),
    .fullyconnected_output(out_a), .class_index(idx_a));

  fc_layer_engine #(.FLATTENED_LENGTH(N), .DATA_WIDTH(DW), .ACC_WIDTH(32), .NUM_OUTPUTS(M),
                    .LANES(L), .OUT_SHIFT(0), .RELU_EN(0)) dut_b (
    .clk(clk), .reset(reset), .start(start), .flattened_outfmap(x_v),
    .fullyconnected_weights(w_v), .bias(b_v), .busy(busy_b), .done(done_b),
    .fullyconnected_output(out_b), .class_index(idx_b));

  fc_layer_engine #(.FLATTENED_LENGTH(N), .DATA_WIDTH(DW), .ACC_WIDTH(32), .NUM_OUTPUTS(M),
                    .LANES(L), .OUT_SHIFT(4), .RELU_EN(0)) dut_c (
    .clk(clk), .reset(reset), .start(start), .flattened_outfmap(x_v),
    .fullyconnected_weights(w_v), .bias(b_v), .busy(busy_c), .done(done_c),
    .fullyconnected_output(out_c), .class_index(idx_c));

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, expv);
    end
  endtask

  function automatic res_t mk(input int o0, input int o1, input int o2, input int idx);
    res_t r;
    r.o[0] = 8'(o0);
    r.o[1] = 8'(o1);
    r.o[2] = 8'(o2);
    r.idx  = 2'(idx);
    return r;
  endfunction

  task automatic mon(input int k, input res_t got);
    res_t e;
    if (q[k].size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_done inst=%0d got=%h expected no result", k, got);
    end else begin
      e = q[k].pop_front();
      $display("txn inst=%0d out=%h idx=%0d exp_out=%h exp_idx=%0d", k, got.o, got.idx, e.o, e.idx);
      check($sformatf("out_inst%0d", k), 64'(got.o), 64'(e.o));
      check($sformatf("idx_inst%0d", k), 64'(got.idx), 64'(e.idx));
    end
  endtask

  always @(negedge clk) begin
    if (done_a === 1'b1) mon(0, {out_a, idx_a});
    if (done_b === 1'b1) mon(1, {out_b, idx_b});
    if (done_c === 1'b1) mon(2, {out_c, idx_c});
  end

  task automatic apply_vec(input int v);
    int xv, w0, w1, w2;
    xv = 1; w0 = 1; w1 = 1; w2 = 1;
    b_v = '0;
    case (v)
      1: begin xv = 255; w0 = 127; w1 = -128; w2 = 0; end
      2: begin xv = 0; b_v[0] = 8'(-5); b_v[1] = 8'd3; end
      3: begin w0 = 12; w1 = -12; w2 = 0; b_v[0] = 8'd4; b_v[1] = 8'(-4); end
      4: begin w0 = 0; b_v[0] = 8'd5; b_v[1] = 8'd1; b_v[2] = 8'd1; end
      5: begin xv = 2; w0 = -1; w1 = -2; w2 = -3; end
      6: begin w0 = 1; w1 = 2; w2 = 3; end
      default: ;
    endcase
    for (int i = 0; i < N; i++) begin
      x_v[i]    = 8'(xv);
      w_v[0][i] = 8'(w0);
      w_v[1][i] = 8'(w1);
      w_v[2][i] = 8'(w2);
      if (v == 7) begin
        x_v[i]    = 8'(i + 1);
        w_v[1][i] = (i % 2 == 0) ? 8'd1 : 8'hFF;
        w_v[2][i] = 8'(i);
      end
    end
  endtask

  task automatic push_exp(input int v);
    for (int k = 0; k < 3; k++) q[k].push_back(exp_tab[k][v]);
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 20 && (q[0].size() + q[1].size() + q[2].size()) != 0; t++) @(posedge clk);
    check(name, 64'(q[0].size() + q[1].size() + q[2].size()), 64'd0);
  endtask

  task automatic run_vec(input int v);
    apply_vec(v);
    @(posedge clk); #1 start = 1'b1;
    push_exp(v);
    @(posedge clk); #1 start = 1'b0;
    drain($sformatf("drain_vec%0d", v));
  endtask

  // Cycle 0 is the start cycle; optional second start in cycle 'restart'.
  task automatic timed(input int restart);
    logic eb, ed;
    apply_vec(0);
    @(posedge clk); #1 start = 1'b1;
    push_exp(0);
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1 start = (c == restart);
      if (c == restart && restart == 6) push_exp(0);
      @(negedge clk);
      eb = (c >= 1 && c <= 5) || (restart == 6 && c >= 7 && c <= 11);
      ed = (c == 6) || (restart == 6 && c == 12);
      check($sformatf("busy_r%0d_c%0d", restart, c), 64'(busy_a), 64'(eb));
      check($sformatf("done_r%0d_c%0d", restart, c), 64'(done_a), 64'(ed));
    end
    drain($sformatf("drain_timed_r%0d", restart));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    exp_tab[0][0] = mk(8, 8, 8, 0);       exp_tab[1][0] = mk(8, 8, 8, 0);         exp_tab[2][0] = mk(0, 0, 0, 0);
    exp_tab[0][1] = mk(127, 0, 0, 0);     exp_tab[1][1] = mk(127, -128, 0, 0);    exp_tab[2][1] = mk(127, -128, 0, 0);
    exp_tab[0][2] = mk(0, 3, 0, 1);       exp_tab[1][2] = mk(-5, 3, 0, 1);        exp_tab[2][2] = mk(-1, 0, 0, 1);
    exp_tab[0][3] = mk(100, 0, 0, 0);     exp_tab[1][3] = mk(100, -100, 0, 0);    exp_tab[2][3] = mk(6, -7, 0, 0);
    exp_tab[0][4] = mk(5, 9, 9, 1);       exp_tab[1][4] = mk(5, 9, 9, 1);         exp_tab[2][4] = mk(0, 0, 0, 0);
    exp_tab[0][5] = mk(0, 0, 0, 0);       exp_tab[1][5] = mk(-16, -32, -48, 0);   exp_tab[2][5] = mk(-1, -2, -3, 0);
    exp_tab[0][6] = mk(8, 16, 24, 2);     exp_tab[1][6] = mk(8, 16, 24, 2);       exp_tab[2][6] = mk(0, 1, 1, 1);
    exp_tab[0][7] = mk(36, 0, 127, 2);    exp_tab[1][7] = mk(36, -4, 127, 2);     exp_tab[2][7] = mk(2, -1, 10, 2);
    apply_vec(0);

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy_a), 64'd0);
    check("reset_done", 64'(done_a), 64'd0);
    check("reset_out", 64'(out_a), 64'd0);
    check("reset_idx", 64'(idx_a), 64'd0);
    reset = 1'b0;

    timed(0);
    timed(3);
    timed(6);
    for (int v = 0; v < 8; v++) run_vec(v);

    // Abort in cycle 3: outputs from the last run must clear immediately.
    apply_vec(0);
    @(posedge clk); #1 start = 1'b1;
    push_exp(0);
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy_a), 64'd0);
    check("abort_out_a", 64'(out_a), 64'd0);
    check("abort_idx_a", 64'(idx_a), 64'd0);
    check("abort_out_c", 64'(out_c), 64'd0);
    for (int k = 0; k < 3; k++) q[k].delete();
    @(posedge clk); #1 reset = 1'b0;
    nd = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (done_a === 1'b1 || done_b === 1'b1 || done_c === 1'b1) nd++;
    end
    check("abort_no_done", 64'(nd), 64'd0);

    run_vec(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
